// File: rtl/bmr_tdee_qsys_pio_led_out.sv
// ============================================================================
// Module  : bmr_tdee_qsys_pio_led_out
// Purpose : Avalon-MM output PIO with data, atomic set/clear and per-bit blink
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bmr_tdee_qsys_pio_led_out #(
  parameter int                DATA_WIDTH  = 8,
  parameter logic [31:0]       RESET_VALUE = 32'h0,
  parameter int                BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int                 c_CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [1:0] c_ADDR_DATA  = 2'd0;
  localparam logic [1:0] c_ADDR_MASK  = 2'd1;
  localparam logic [1:0] c_ADDR_SET   = 2'd2;
  localparam logic [1:0] c_ADDR_CLEAR = 2'd3;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  unused_wd;

  assign w_wr      = chipselect & ~write_n;
  assign w_wd      = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    if (cnt_q == c_CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + c_CNT_ONE;
    end

    // A mask write restarts the blink in its visible phase, overriding any wrap.
    if (w_wr) begin
      case (address)
        c_ADDR_DATA:  data_d = w_wd;
        c_ADDR_MASK: begin
          mask_d  = w_wd;
          cnt_d   = '0;
          phase_d = 1'b1;
        end
        c_ADDR_SET:   data_d = data_q | w_wd;
        default:      data_d = data_q & ~w_wd;
      endcase
    end
  end

  // Read mux uses current register values, so a same-edge write reads old data.
  always_comb begin
    readdata_d = '0;
    case (address)
      c_ADDR_DATA:  readdata_d[DATA_WIDTH-1:0] = data_q;
      c_ADDR_MASK:  readdata_d[DATA_WIDTH-1:0] = mask_q;
      c_ADDR_SET:   readdata_d[0]              = phase_q;
      c_ADDR_CLEAR: readdata_d                 = '0;
      default:      readdata_d                 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE[DATA_WIDTH-1:0];
      mask_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q & (~mask_q | {DATA_WIDTH{phase_q}});

endmodule

`default_nettype wire
